// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC register, single-outstanding fetch, decode handoff
// Applies delayed-slot redirects from decode and exception/ERET flushes from CP0.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] EXC_PC   = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_redirect,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] jr_target,
    input  logic        exc_flush,
    input  logic        eret_flush,
    input  logic [31:0] epc,
    input  logic        id_allowin,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_CANCEL
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    logic        r_pend;
    logic        w_pend_nxt;
    logic [31:0] r_pend_target;
    logic [31:0] w_pend_target_nxt;
    logic        r_inst_req;
    logic        r_if_valid;
    logic        w_if_valid_nxt;
    logic [31:0] r_if_inst;
    logic [31:0] w_if_inst_nxt;
    logic        r_if_adel;
    logic        w_if_adel_nxt;

    logic        w_flush;
    logic [31:0] w_flush_pc;
    logic        w_redir;
    logic [31:0] w_redir_tgt;
    logic [31:0] w_handoff_pc;
    logic        w_accepted;

    assign w_flush    = exc_flush | eret_flush;
    assign w_flush_pc = exc_flush ? EXC_PC : epc;
    assign w_redir    = br_redirect && (pcsource != 2'b00);
    assign w_accepted = r_inst_req && inst_addr_ok;

    always_comb begin
        w_redir_tgt = bpc;
        case (pcsource)
            2'b01:   w_redir_tgt = jr_target;
            2'b10:   w_redir_tgt = jpc;
            default: w_redir_tgt = bpc;
        endcase
    end

    // A redirect arriving in the same cycle as the slot handoff must still win over pc+4.
    assign w_handoff_pc = w_redir ? w_redir_tgt :
                          r_pend  ? r_pend_target : (r_fetch_pc + 32'd4);

    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_pend_nxt        = r_pend;
        w_pend_target_nxt = r_pend_target;
        w_if_valid_nxt    = r_if_valid;
        w_if_inst_nxt     = r_if_inst;
        w_if_adel_nxt     = r_if_adel;

        if (w_flush) begin
            w_fetch_pc_nxt = w_flush_pc;
            w_pend_nxt     = 1'b0;
            w_if_valid_nxt = 1'b0;
            w_if_adel_nxt  = 1'b0;
            case (r_state)
                S_REQ:    w_state_nxt = w_accepted ? S_CANCEL : S_REQ;
                S_WAIT:   w_state_nxt = inst_data_ok ? S_REQ : S_CANCEL;
                S_CANCEL: w_state_nxt = inst_data_ok ? S_REQ : S_CANCEL;
                default:  w_state_nxt = S_REQ;
            endcase
        end else begin
            if (w_redir) begin
                w_pend_nxt        = 1'b1;
                w_pend_target_nxt = w_redir_tgt;
            end
            case (r_state)
                S_REQ: begin
                    if (w_accepted) w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        w_if_inst_nxt  = inst_rdata;
                        w_if_valid_nxt = 1'b1;
                        w_if_adel_nxt  = 1'b0;
                        w_state_nxt    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (id_allowin) begin
                        w_if_valid_nxt = 1'b0;
                        w_if_adel_nxt  = 1'b0;
                        w_fetch_pc_nxt = w_handoff_pc;
                        w_pend_nxt     = 1'b0;
                        w_state_nxt    = S_REQ;
                    end
                end
                default: begin
                    if (inst_data_ok) w_state_nxt = S_REQ;
                end
            endcase
        end

        // Misaligned PCs never reach the bus; they surface as an address-error instruction.
        if ((w_state_nxt == S_REQ) && (w_fetch_pc_nxt[1:0] != 2'b00)) begin
            w_state_nxt    = S_HOLD;
            w_if_valid_nxt = 1'b1;
            w_if_adel_nxt  = 1'b1;
            w_if_inst_nxt  = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_REQ;
            r_fetch_pc    <= RESET_PC;
            r_pend        <= 1'b0;
            r_pend_target <= 32'd0;
            r_inst_req    <= 1'b0;
            r_if_valid    <= 1'b0;
            r_if_inst     <= 32'd0;
            r_if_adel     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_pend        <= w_pend_nxt;
            r_pend_target <= w_pend_target_nxt;
            r_inst_req    <= (w_state_nxt == S_REQ);
            r_if_valid    <= w_if_valid_nxt;
            r_if_inst     <= w_if_inst_nxt;
            r_if_adel     <= w_if_adel_nxt;
        end
    end

    assign inst_req  = r_inst_req;
    assign inst_addr = {r_fetch_pc[31:2], 2'b00};
    assign if_valid  = r_if_valid;
    assign if_pc     = r_fetch_pc;
    assign if_inst   = r_if_inst;
    assign if_adel   = r_if_adel;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed bench for if_stage with a latency-programmable instruction memory
module tb_if_stage;

    logic        clk;
    logic        resetn;
    logic        br_redirect;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] jr_target;
    logic        exc_flush;
    logic        eret_flush;
    logic [31:0] epc;
    logic        id_allowin;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    int total = 0;
    int bad   = 0;

    int          m_lat;
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_addr;
    logic [31:0] acc_q[$];
    logic [31:0] ho_q[$];

    logic [31:0] exp_acc [10] = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC00100,
                                  32'hBFC00104, 32'hBFC00380, 32'hBFC00384, 32'h80001234,
                                  32'hBFC00380, 32'hBFC00000};
    logic [31:0] exp_ho [6]   = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC00100,
                                  32'hBFC00380, 32'h80001234};

    if_stage dut (
        .clk          (clk),
        .resetn       (resetn),
        .br_redirect  (br_redirect),
        .pcsource     (pcsource),
        .bpc          (bpc),
        .jpc          (jpc),
        .jr_target    (jr_target),
        .exc_flush    (exc_flush),
        .eret_flush   (eret_flush),
        .epc          (epc),
        .id_allowin   (id_allowin),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_adel      (if_adel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h24080000 | {16'h0, a[17:2]};
    endfunction

    assign inst_addr_ok = inst_req;

    always @(posedge clk) begin
        inst_data_ok <= 1'b0;
        if (m_busy) begin
            if (m_cnt <= 1) begin
                inst_data_ok <= 1'b1;
                inst_rdata   <= word_of(m_addr);
                m_busy       <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
        if (inst_req && inst_addr_ok) begin
            acc_q.push_back(inst_addr);
            if (m_lat <= 1) begin
                inst_data_ok <= 1'b1;
                inst_rdata   <= word_of(inst_addr);
            end else begin
                m_busy <= 1'b1;
                m_cnt  <= m_lat - 1;
                m_addr <= inst_addr;
            end
        end
        if (if_valid && id_allowin) ho_q.push_back(if_pc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!if_valid && n < 12) begin
            tick();
            n++;
        end
        chk(tag, 32'(if_valid), 1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!inst_req && n < 12) begin
            chk({tag, "_nvalid"}, 32'(if_valid), 0);
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(inst_req), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(inst_req), 0);
        chk({tag, "_addr"},  inst_addr, 32'hBFC00000);
        chk({tag, "_valid"}, 32'(if_valid), 0);
        chk({tag, "_pc"},    if_pc, 32'hBFC00000);
        chk({tag, "_inst"},  if_inst, 0);
        chk({tag, "_adel"},  32'(if_adel), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b1; br_redirect = 1'b0; pcsource = 2'b00;
        bpc = 32'd0; jpc = 32'd0; jr_target = 32'd0;
        exc_flush = 1'b0; eret_flush = 1'b0; epc = 32'd0; id_allowin = 1'b0;
        m_lat = 1; m_busy = 1'b0; m_cnt = 0; m_addr = 32'd0;
        inst_data_ok = 1'b0; inst_rdata = 32'd0;
        #1 resetn = 1'b0;
        #1 check_reset_outputs("rst");
        id_allowin = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #7 resetn = 1'b1;
        tick();

        // sequential fetch: one instruction every third cycle
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("seq_valid%0d", i), 32'(if_valid), (i % 3 == 2) ? 1 : 0);
            if (i % 3 == 2) begin
                chk($sformatf("seq_pc%0d", i), if_pc, 32'hBFC00000 + 32'(4 * (i / 3)));
                chk($sformatf("seq_inst%0d", i), if_inst, 32'h24080000 + 32'(i / 3));
            end
            if (i == 7) id_allowin = 1'b0;
            if (i != 8) tick();
        end

        // stall in HOLD with a taken branch raised in the first stalled cycle
        jr_target = 32'hBFC00200; jpc = 32'hBFC00300;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_pc%0d", i), if_pc, 32'hBFC00008);
            chk($sformatf("stall_inst%0d", i), if_inst, 32'h24080002);
            chk($sformatf("stall_valid%0d", i), 32'(if_valid), 1);
            chk($sformatf("stall_req%0d", i), 32'(inst_req), 0);
            br_redirect = (i == 0);
            pcsource    = 2'b11;
            bpc         = 32'hBFC00100;
            if (i == 4) id_allowin = 1'b1;
            tick();
        end
        br_redirect = 1'b0;
        id_allowin  = 1'b0;
        chk("br_valid", 32'(if_valid), 0);
        chk("br_req", 32'(inst_req), 1);
        chk("br_addr", inst_addr, 32'hBFC00100);
        wait_valid("br_hold");
        chk("br_pc", if_pc, 32'hBFC00100);
        chk("br_inst", if_inst, 32'h24080040);

        // exception flush while the request is outstanding
        id_allowin = 1'b1; m_lat = 3;
        tick();
        id_allowin = 1'b0;
        tick();
        chk("exc_in_wait", 32'(inst_req), 0);
        exc_flush = 1'b1;
        tick();
        exc_flush = 1'b0;
        wait_req("exc");
        chk("exc_addr", inst_addr, 32'hBFC00380);
        m_lat = 1;
        wait_valid("exc_hold");
        chk("exc_pc", if_pc, 32'hBFC00380);
        chk("exc_inst", if_inst, 32'h240800E0);

        // ERET flush while the request is outstanding
        id_allowin = 1'b1; m_lat = 3;
        tick();
        id_allowin = 1'b0;
        tick();
        chk("eret_in_wait", 32'(inst_req), 0);
        eret_flush = 1'b1; epc = 32'h80001234;
        tick();
        eret_flush = 1'b0;
        wait_req("eret");
        chk("eret_addr", inst_addr, 32'h80001234);
        m_lat = 1;
        wait_valid("eret_hold");
        chk("eret_pc", if_pc, 32'h80001234);
        chk("eret_inst", if_inst, 32'h2408048D);

        // misaligned jr target after the delay slot
        br_redirect = 1'b1; pcsource = 2'b01;
        jr_target = 32'h80000002; jpc = 32'h80000100; bpc = 32'h80000200;
        tick();
        br_redirect = 1'b0;
        id_allowin  = 1'b1;
        tick();
        id_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("adel_valid%0d", i), 32'(if_valid), 1);
            chk($sformatf("adel_flag%0d", i), 32'(if_adel), 1);
            chk($sformatf("adel_pc%0d", i), if_pc, 32'h80000002);
            chk($sformatf("adel_inst%0d", i), if_inst, 0);
            chk($sformatf("adel_req%0d", i), 32'(inst_req), 0);
            if (i != 2) tick();
        end

        // flush from HOLD, then asynchronous reset while waiting for data
        exc_flush = 1'b1; m_lat = 3;
        tick();
        exc_flush = 1'b0;
        chk("hflush_req", 32'(inst_req), 1);
        chk("hflush_addr", inst_addr, 32'hBFC00380);
        chk("hflush_valid", 32'(if_valid), 0);
        chk("hflush_adel", 32'(if_adel), 0);
        tick();
        #3 resetn = 1'b0;
        #1 check_reset_outputs("arst");
        @(posedge clk);
        #2 resetn = 1'b1; m_lat = 1;
        tick();
        chk("arst_req_rise", 32'(inst_req), 1);
        chk("arst_first_addr", inst_addr, 32'hBFC00000);
        wait_valid("arst_hold");
        chk("arst_pc", if_pc, 32'hBFC00000);
        chk("arst_inst", if_inst, 32'h24080000);

        chk("acc_count", 32'(acc_q.size()), 10);
        for (int i = 0; i < 10; i++)
            if (i < acc_q.size()) chk($sformatf("acc%0d", i), acc_q[i], exp_acc[i]);
        chk("ho_count", 32'(ho_q.size()), 6);
        for (int i = 0; i < 6; i++)
            if (i < ho_q.size()) chk($sformatf("ho%0d", i), ho_q[i], exp_ho[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the PC register and issues word fetches on the SRAM-like instruction port, allowing one request in flight. It hands each instruction and its PC to decode with a valid/allowin handshake. It applies decode's redirect (pcsource with bpc/jpc/jr_target) after the delay slot, and applies exception/ERET flushes from CP0.

## Interface
- RESET_PC, 32'hBFC0_0000, address fetched first after reset
- EXC_PC, 32'hBFC0_0380, exception entry vector
- clk  in  1  clock; all state changes on the rising edge
- resetn  in  1  reset, asynchronous and active-low
- br_redirect  in  1  decode holds a valid instruction with pcsource != 00 this cycle; a one-cycle pulse per transfer
- pcsource  in  2  redirect select: 01 selects jr_target, 10 selects jpc, 11 selects bpc
- bpc, jpc, jr_target  in  32 each  redirect targets
- exc_flush  in  1  exception taken; refetch from EXC_PC
- eret_flush  in  1  ERET; refetch from epc
- epc  in  32  ERET return address
- id_allowin  in  1  decode accepts the IF instruction this cycle
- inst_req  out  1  fetch request
- inst_addr  out  32  fetch address, word aligned
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  read data valid
- inst_rdata  in  32  instruction word
- if_valid  out  1  if_pc/if_inst/if_adel are valid for decode
- if_pc, if_inst  out  32 each  PC and instruction handed to decode
- if_adel  out  1  fetch address error; if_inst is 0

## Operation
- Registers:
  - fetch_pc: address of the instruction being fetched or held.
  - pend: 1-bit redirect pending flag.
  - pend_target: 32-bit pending redirect address.
  - state.
- States:
  - REQ: inst_req=1 and inst_addr=fetch_pc. Stay in REQ until inst_addr_ok, then go to WAIT. Once raised, req and addr are held until accepted.
  - WAIT: on inst_data_ok, capture inst_rdata into if_inst, set if_valid, go to HOLD.
  - HOLD: if_valid=1. On id_allowin, clear if_valid and set fetch_pc to the next PC. Go to REQ, or to HOLD-with-ADEL if the next PC is misaligned.
  - CANCEL: a flushed request is still in flight. Wait for its inst_data_ok, discard the data, then go to REQ.
- Next PC on handoff: pend ? pend_target : fetch_pc+4 (wraps mod 2^32). pend is cleared on the handoff.
- Redirect:
  - On br_redirect, set pend=1 and pend_target to the target chosen by pcsource.
  - The instruction currently at fetch_pc is the delay slot. It is delivered normally; the target is fetched next.
  - br_redirect with pcsource=00 is ignored.
  - A second redirect while pend=1 overwrites pend_target.
- Misaligned PC (fetch_pc[1:0]!=0):
  - No request is issued.
  - Enter HOLD with if_valid=1, if_adel=1, if_inst=0, if_pc=fetch_pc.
- Flush:
  - exc_flush takes priority over eret_flush, and both take priority over redirect and handoff.
  - fetch_pc becomes EXC_PC (exception) or epc (ERET). pend and if_valid are cleared.
  - Next state depends on the state at the flush:
    - REQ: request not yet accepted. Stay in REQ; the new address is driven from the next cycle.
    - REQ with inst_addr_ok in the same cycle: go to CANCEL.
    - WAIT: go to CANCEL. If inst_data_ok arrives in the flush cycle itself, the data is dropped and the next state is REQ.
    - HOLD: go to REQ.

## Timing
- Reset values (asynchronous): inst_req=0, inst_addr=RESET_PC, if_valid=0, if_pc=RESET_PC, if_inst=0, if_adel=0, pend=0, state REQ. fetch_pc is also RESET_PC.
- inst_req rises on the first rising edge after resetn deasserts.
- All outputs are registered; there are no combinational paths from any input to any output.
- With zero-wait memory (addr_ok in the req cycle, data_ok one cycle later), the sequence is:
  - cycle 0: REQ.
  - cycle 1: WAIT, data captured.
  - cycle 2: HOLD, if_valid=1.
  - Throughput is one instruction per 3 cycles with id_allowin held high.
- While id_allowin=0, if_pc, if_inst and if_valid stay stable and no request is issued.
- Asynchronous reset mid-transaction returns everything to reset values immediately. A late inst_data_ok arriving after reset is ignored, since state is REQ.

## Test plan
- Sequential fetch: release resetn with zero-wait memory returning 0x2408000N at address 4N → inst_addr sequence BFC00000, BFC00004, BFC00008; if_inst matches each word; if_valid pulses every 3rd cycle.
- Taken branch: while HOLD has if_pc=BFC00008, assert br_redirect with pcsource=11 and bpc=BFC00100 → BFC00008 is delivered once; the next inst_addr is BFC00100.
- Stall: id_allowin=0 for 5 cycles in HOLD → if_pc and if_inst unchanged, inst_req=0 throughout; handoff follows on the first cycle id_allowin=1.
- Flush in WAIT: exc_flush while a request is outstanding, data_ok delayed 3 cycles → returned word is not presented on if_inst and if_valid stays 0; the next request uses BFC00380. Repeat with eret_flush and epc=80001234 → next request uses 80001234.
- Misaligned jr: redirect with pcsource=01 and jr_target=80000002 → after the slot, inst_req stays 0; if_valid=1, if_adel=1, if_pc=80000002, if_inst=0.
- Reset mid-WAIT: drop resetn asynchronously → outputs take reset values before the next edge; after release, the first fetch is BFC00000 and the stale data_ok is ignored.
